// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: starts the shared multiplier or divider, watches it for
// completion, divide-by-zero, timeout or flush, then issues a single-cycle
// HI/LO write with the matching result source select.
module muldiv_sequencer #(
  parameter int MULT_TIMEOUT = 40,
  parameter int DIV_TIMEOUT  = 40,
  parameter int CNT_W        = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic req_mult,
  input  logic req_div,
  input  logic flush,
  input  logic mult_done,
  input  logic div_done,
  input  logic div_zero,
  output logic mult_start,
  output logic div_start,
  output logic Mult_Div,
  output logic HIWrite,
  output logic LOWrite,
  output logic busy,
  output logic done,
  output logic div0_excp,
  output logic timeout,
  output logic req_collide
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULT_RUN = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_WRITE    = 2'd3
  } state_t;

  // Last counter value allowed in each run state before the unit is abandoned.
  localparam logic [CNT_W-1:0] L_MULT_LAST = CNT_W'(MULT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_DIV_LAST  = CNT_W'(DIV_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mult_start;
  logic             r_div_start;
  logic             r_mult_div;
  logic             r_hi_write;
  logic             r_lo_write;
  logic             r_busy;
  logic             r_done;
  logic             r_div0_excp;
  logic             r_timeout;
  logic             r_req_collide;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mult_start  <= 1'b0;
      r_div_start   <= 1'b0;
      r_mult_div    <= 1'b0;
      r_hi_write    <= 1'b0;
      r_lo_write    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div0_excp   <= 1'b0;
      r_timeout     <= 1'b0;
      r_req_collide <= 1'b0;
    end else begin
      // Pulses and write enables last one cycle unless re-asserted below.
      r_hi_write    <= 1'b0;
      r_lo_write    <= 1'b0;
      r_done        <= 1'b0;
      r_div0_excp   <= 1'b0;
      r_timeout     <= 1'b0;
      r_req_collide <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A flush in the same cycle cancels any request; mult wins a tie.
          if (!flush) begin
            if (req_mult) begin
              r_state       <= S_MULT_RUN;
              r_cnt         <= '0;
              r_mult_start  <= 1'b1;
              r_mult_div    <= 1'b0;
              r_busy        <= 1'b1;
              r_req_collide <= req_div;
            end else if (req_div) begin
              r_state     <= S_DIV_RUN;
              r_cnt       <= '0;
              r_div_start <= 1'b1;
              r_mult_div  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end

        S_MULT_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (flush) begin
            r_state      <= S_IDLE;
            r_mult_start <= 1'b0;
            r_busy       <= 1'b0;
          end else if (mult_done) begin
            r_state      <= S_WRITE;
            r_mult_start <= 1'b0;
            r_hi_write   <= 1'b1;
            r_lo_write   <= 1'b1;
            r_done       <= 1'b1;
          end else if (r_cnt == L_MULT_LAST) begin
            r_state      <= S_IDLE;
            r_mult_start <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b1;
          end
        end

        S_DIV_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          // Divide-by-zero beats a simultaneous done so no bogus result is written.
          if (flush) begin
            r_state     <= S_IDLE;
            r_div_start <= 1'b0;
            r_busy      <= 1'b0;
          end else if (div_zero) begin
            r_state     <= S_IDLE;
            r_div_start <= 1'b0;
            r_busy      <= 1'b0;
            r_div0_excp <= 1'b1;
          end else if (div_done) begin
            r_state     <= S_WRITE;
            r_div_start <= 1'b0;
            r_hi_write  <= 1'b1;
            r_lo_write  <= 1'b1;
            r_done      <= 1'b1;
          end else if (r_cnt == L_DIV_LAST) begin
            r_state     <= S_IDLE;
            r_div_start <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b1;
          end
        end

        S_WRITE: begin
          // Write enables were raised on entry; they drop here by default.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_mult_start <= 1'b0;
          r_div_start  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign mult_start  = r_mult_start;
  assign div_start   = r_div_start;
  assign Mult_Div    = r_mult_div;
  assign HIWrite     = r_hi_write;
  assign LOWrite     = r_lo_write;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div0_excp   = r_div0_excp;
  assign timeout     = r_timeout;
  assign req_collide = r_req_collide;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: each task drives one scenario and
// checks outputs 1 ns after the rising edge against hand-derived values.
module tb_muldiv_sequencer;

  logic clock = 1'b0;
  logic reset, req_mult, req_div, flush, mult_done, div_done, div_zero;
  logic mult_start, div_start, Mult_Div, HIWrite, LOWrite, busy, done;
  logic div0_excp, timeout, req_collide;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sequencer #(.MULT_TIMEOUT(40), .DIV_TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
    .flush(flush), .mult_done(mult_done), .div_done(div_done), .div_zero(div_zero),
    .mult_start(mult_start), .div_start(div_start), .Mult_Div(Mult_Div),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .busy(busy), .done(done),
    .div0_excp(div0_excp), .timeout(timeout), .req_collide(req_collide)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs set afterwards are sampled at the following edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_mult = 0; req_div = 0; flush = 0;
    mult_done = 0; div_done = 0; div_zero = 0;
    tick(); tick();
    n_checks++; if ({mult_start, div_start, Mult_Div, HIWrite, LOWrite, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {mult_start, div_start, Mult_Div, HIWrite, LOWrite, busy}); end
    n_checks++; if ({done, div0_excp, timeout, req_collide} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {done, div0_excp, timeout, req_collide}); end
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_mult_done33();
    int bad_start = 0;
    int early_wr  = 0;
    req_mult = 1; tick(); req_mult = 0;          // now in RUN cycle 1
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_c1: got %b expected 1", busy); end
    for (int c = 1; c <= 33; c++) begin
      if (mult_start !== 1'b1) bad_start++;
      if (HIWrite !== 1'b0 || LOWrite !== 1'b0 || done !== 1'b0) early_wr++;
      if (c == 33) mult_done = 1;
      tick();
    end
    mult_done = 0;                                // cycle 34: WRITE
    n_checks++; if (bad_start != 0) begin n_fail++; $display("FAIL mult_start_33: got %0d low cycles expected 0", bad_start); end
    n_checks++; if (early_wr != 0) begin n_fail++; $display("FAIL mult_early_write: got %0d cycles expected 0", early_wr); end
    n_checks++; if ({HIWrite, LOWrite, done} !== 3'b111) begin n_fail++; $display("FAIL mult_write: got %b expected 111", {HIWrite, LOWrite, done}); end
    n_checks++; if ({mult_start, Mult_Div, busy} !== 3'b001) begin n_fail++; $display("FAIL mult_write_ctrl: got %b expected 001", {mult_start, Mult_Div, busy}); end
    tick();                                       // cycle 35: IDLE
    n_checks++; if ({HIWrite, LOWrite, done, busy} !== 4'b0) begin n_fail++; $display("FAIL mult_after: got %b expected 0000", {HIWrite, LOWrite, done, busy}); end
    $display("test_mult_done33 done");
  endtask

  task automatic test_div_zero();
    req_div = 1; tick(); req_div = 0;             // DIV_RUN cycle 1
    n_checks++; if ({div_start, Mult_Div, busy} !== 3'b111) begin n_fail++; $display("FAIL div_start: got %b expected 111", {div_start, Mult_Div, busy}); end
    tick();                                       // DIV_RUN cycle 2
    div_zero = 1; div_done = 1;
    tick();
    div_zero = 0; div_done = 0;
    n_checks++; if (div0_excp !== 1'b1) begin n_fail++; $display("FAIL div0_pulse: got %b expected 1", div0_excp); end
    n_checks++; if ({HIWrite, LOWrite, done, busy, div_start} !== 5'b0) begin n_fail++; $display("FAIL div0_nowrite: got %b expected 00000", {HIWrite, LOWrite, done, busy, div_start}); end
    n_checks++; if (Mult_Div !== 1'b1) begin n_fail++; $display("FAIL div0_muldiv: got %b expected 1", Mult_Div); end
    tick();
    n_checks++; if ({div0_excp, HIWrite, LOWrite, busy} !== 4'b0) begin n_fail++; $display("FAIL div0_after: got %b expected 0000", {div0_excp, HIWrite, LOWrite, busy}); end
    $display("test_div_zero done");
  endtask

  task automatic test_collision();
    req_mult = 1; req_div = 1; tick(); req_mult = 0; req_div = 0;
    n_checks++; if ({mult_start, div_start, req_collide, Mult_Div} !== 4'b1010) begin n_fail++; $display("FAIL collide_entry: got %b expected 1010", {mult_start, div_start, req_collide, Mult_Div}); end
    tick();
    n_checks++; if ({req_collide, div_start, mult_start} !== 3'b001) begin n_fail++; $display("FAIL collide_after: got %b expected 001", {req_collide, div_start, mult_start}); end
    mult_done = 1; tick(); mult_done = 0;
    n_checks++; if ({done, Mult_Div, div_start} !== 3'b100) begin n_fail++; $display("FAIL collide_write: got %b expected 100", {done, Mult_Div, div_start}); end
    tick();
    $display("test_collision done");
  endtask

  task automatic test_timeout();
    int bad = 0;
    req_mult = 1; tick(); req_mult = 0;           // cycle 1
    for (int c = 1; c <= 40; c++) begin
      if (busy !== 1'b1 || timeout !== 1'b0) bad++;
      tick();
    end                                           // now cycle 41
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_run: got %0d bad cycles expected 0", bad); end
    n_checks++; if ({timeout, busy, mult_start} !== 3'b100) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 100", {timeout, busy, mult_start}); end
    n_checks++; if ({HIWrite, LOWrite, done} !== 3'b0) begin n_fail++; $display("FAIL timeout_nowrite: got %b expected 000", {HIWrite, LOWrite, done}); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_len: got %b expected 0", timeout); end
    $display("test_timeout done");
  endtask

  task automatic test_flush();
    flush = 1; req_mult = 1; tick(); flush = 0; req_mult = 0;
    n_checks++; if ({busy, mult_start} !== 2'b00) begin n_fail++; $display("FAIL flush_idle_req: got %b expected 00", {busy, mult_start}); end
    req_div = 1; tick(); req_div = 0;             // DIV_RUN cycle 1
    tick();                                       // DIV_RUN cycle 2
    flush = 1; div_done = 1; tick(); flush = 0; div_done = 0;
    n_checks++; if ({HIWrite, LOWrite, done, busy, div_start} !== 5'b0) begin n_fail++; $display("FAIL flush_vs_done: got %b expected 00000", {HIWrite, LOWrite, done, busy, div_start}); end
    tick();
    n_checks++; if ({HIWrite, done, div0_excp, timeout} !== 4'b0) begin n_fail++; $display("FAIL flush_after: got %b expected 0000", {HIWrite, done, div0_excp, timeout}); end
    req_mult = 1; tick(); req_mult = 0;
    n_checks++; if ({mult_start, busy, Mult_Div} !== 3'b110) begin n_fail++; $display("FAIL flush_next_req: got %b expected 110", {mult_start, busy, Mult_Div}); end
    mult_done = 1; tick(); mult_done = 0;
    n_checks++; if ({HIWrite, LOWrite, done} !== 3'b111) begin n_fail++; $display("FAIL flush_next_write: got %b expected 111", {HIWrite, LOWrite, done}); end
    tick();
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    req_mult = 1; tick(); req_mult = 0;           // cycle 1 RUN
    mult_done = 1; tick(); mult_done = 0;         // cycle 2 WRITE
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_write: got %b expected 1", done); end
    req_div = 1; tick(); req_div = 0;             // request during WRITE is dropped
    n_checks++; if ({busy, div_start} !== 2'b00) begin n_fail++; $display("FAIL b2b_ignored: got %b expected 00", {busy, div_start}); end
    req_div = 1; tick(); req_div = 0;             // accepted in first IDLE cycle
    n_checks++; if ({div_start, Mult_Div, busy} !== 3'b111) begin n_fail++; $display("FAIL b2b_accept: got %b expected 111", {div_start, Mult_Div, busy}); end
    div_done = 1; tick(); div_done = 0;
    n_checks++; if ({HIWrite, LOWrite, done, Mult_Div, div_start} !== 5'b11110) begin n_fail++; $display("FAIL b2b_div_write: got %b expected 11110", {HIWrite, LOWrite, done, Mult_Div, div_start}); end
    tick();
    n_checks++; if ({busy, Mult_Div} !== 2'b01) begin n_fail++; $display("FAIL b2b_hold_src: got %b expected 01", {busy, Mult_Div}); end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    req_mult = 1; tick(); req_mult = 0; tick();   // MULT_RUN cycle 2
    #2 reset = 1;
    #1;
    n_checks++; if ({mult_start, busy, Mult_Div} !== 3'b000) begin n_fail++; $display("FAIL areset_mult: got %b expected 000", {mult_start, busy, Mult_Div}); end
    #1 reset = 0;
    tick();
    req_div = 1; tick(); req_div = 0;
    n_checks++; if ({div_start, busy, Mult_Div} !== 3'b111) begin n_fail++; $display("FAIL areset_div_start: got %b expected 111", {div_start, busy, Mult_Div}); end
    #2 reset = 1;
    #1;
    n_checks++; if ({div_start, busy, Mult_Div, HIWrite} !== 4'b0) begin n_fail++; $display("FAIL areset_div: got %b expected 0000", {div_start, busy, Mult_Div, HIWrite}); end
    #1 reset = 0;
    tick();
    n_checks++; if ({busy, HIWrite, done} !== 3'b0) begin n_fail++; $display("FAIL areset_idle: got %b expected 000", {busy, HIWrite, done}); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_mult_done33();
    test_div_zero();
    test_collision();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
